// File: rtl/dec_sweep_pkg.sv
// Shared types and constants for the decoder sweep controller.
package dec_sweep_pkg;
   localparam int   IN_W        = 8;
   localparam int   OUT_W       = 256;
   localparam logic MODE_SWEEP  = 1'b0;
   localparam logic MODE_STREAM = 1'b1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, DONE} state_t;
endpackage

// File: rtl/dec_sweep_popcnt.sv
// Adder-tree popcount of the decoder error vector (used with DEC_SWEEP_HAMMING_EN).
module dec_sweep_popcnt
   import dec_sweep_pkg::*;
(
   input  logic [OUT_W-1:0]       i_vec,
   output logic [$clog2(OUT_W):0] o_cnt
);
   localparam int CW = $clog2(OUT_W) + 1;

   // Heap layout: node n sums children 2n and 2n+1; leaves sit at OUT_W..2*OUT_W-1.
   logic [CW-1:0] w_sum [1:2*OUT_W-1];

   genvar g;
   generate
      for (g = 0; g < OUT_W; g++) begin : g_leaf
         assign w_sum[OUT_W+g] = CW'(i_vec[g]);
      end
      for (g = 1; g < OUT_W; g++) begin : g_node
         assign w_sum[g] = w_sum[2*g] + w_sum[2*g+1];
      end
   endgenerate

   assign o_cnt = w_sum[1];
endmodule

// File: rtl/dec_sweep_ctrl.sv
// Drives the 8->256 one-hot decoder from a sweep or stream and counts wrong outputs.
// Optional DEC_SWEEP_HAMMING_EN adds o_ham_max (worst per-vector Hamming distance).
module dec_sweep_ctrl
   import dec_sweep_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [CNT_W-1:0] i_num_vec,
   input  logic             i_s_valid,
   input  logic [IN_W-1:0]  i_s_data,
   output logic             o_s_ready,
   output logic [IN_W-1:0]  o_dec_in,
   input  logic [127:0]     i_dec_out0,
   input  logic [127:0]     i_dec_out1,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_vec_cnt,
   output logic [CNT_W-1:0] o_err_cnt
`ifdef DEC_SWEEP_HAMMING_EN
   ,
   output logic [8:0]       o_ham_max
`endif
);
   localparam int SW = $clog2(SETTLE + 1);

   state_t             r_state, w_nxt;
   logic               r_mode;
   logic [CNT_W:0]     r_target;
   logic [IN_W-1:0]    r_idx;
   logic [IN_W-1:0]    r_dec_in;
   logic [SW-1:0]      r_settle;
   logic [OUT_W-1:0]   r_cap;
   logic [CNT_W-1:0]   r_vec_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [OUT_W-1:0]   w_exp;
   logic [CNT_W:0]     w_vec_nxt;
   logic               w_take;
   logic               w_settled;
   logic               w_mis;

   assign w_exp     = OUT_W'(1) << r_dec_in;
   assign w_mis     = (r_cap != w_exp);
   assign w_vec_nxt = {1'b0, r_vec_cnt} + 1'b1;
   assign w_take    = (r_mode == MODE_SWEEP) || i_s_valid;
   assign w_settled = (r_settle == SW'(1));

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:  if (i_start)
                   w_nxt = (i_mode == MODE_STREAM && i_num_vec == '0) ? DONE : FETCH;
         FETCH: if (w_take) w_nxt = WAIT;
         WAIT:  if (w_settled) w_nxt = CHECK;
         CHECK: w_nxt = (w_vec_nxt == r_target) ? DONE : FETCH;
         DONE:  w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode    <= MODE_SWEEP;
         r_target  <= '0;
         r_idx     <= '0;
         r_dec_in  <= '0;
         r_settle  <= '0;
         r_cap     <= '0;
         r_vec_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_start) begin
               r_vec_cnt <= '0;
               r_err_cnt <= '0;
               r_mode    <= i_mode;
               r_target  <= (i_mode == MODE_SWEEP) ? (CNT_W+1)'(OUT_W) : {1'b0, i_num_vec};
               r_idx     <= '0;
            end
            FETCH: if (w_take) begin
               r_dec_in <= (r_mode == MODE_SWEEP) ? r_idx : i_s_data;
               r_settle <= SW'(SETTLE);
            end
            WAIT: begin
               if (w_settled) r_cap <= {i_dec_out1, i_dec_out0};
               else           r_settle <= r_settle - 1'b1;
            end
            CHECK: begin
               r_vec_cnt <= w_vec_nxt[CNT_W-1:0];
               if (w_mis) r_err_cnt <= r_err_cnt + 1'b1;
               // Wraps 255->0 only after the final sweep check, so harmless.
               r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DEC_SWEEP_HAMMING_EN
   logic [8:0] w_pop;
   logic [8:0] r_ham_max;

   dec_sweep_popcnt u_popcnt (
      .i_vec (r_cap ^ w_exp),
      .o_cnt (w_pop)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)                             r_ham_max <= '0;
      else if (r_state == IDLE && i_start)   r_ham_max <= '0;
      else if (r_state == CHECK && w_pop > r_ham_max) r_ham_max <= w_pop;
   end

   assign o_ham_max = r_ham_max;
`endif

   assign o_s_ready = (r_state == FETCH) && (r_mode == MODE_STREAM);
   assign o_busy    = (r_state != IDLE);
   assign o_done    = (r_state == DONE);
   assign o_dec_in  = r_dec_in;
   assign o_vec_cnt = r_vec_cnt;
   assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_dec_sweep_ctrl.sv
// Self-checking bench for dec_sweep_ctrl with a behavioural (optionally faulty) decoder.
module tb_dec_sweep_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic [19:0]  num_vec = '0;
   logic         s_valid = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_ready;
   logic [7:0]   dec_in;
   logic [127:0] dec_out0, dec_out1;
   logic         busy, done;
   logic [19:0]  vec_cnt, err_cnt;
`ifdef DEC_SWEEP_HAMMING_EN
   logic [8:0]   ham_max;
`endif

   int errors = 0;
   int checks = 0;
   int fault  = 0;
   logic [7:0] exp_q [$];
   logic [255:0] w_dec;

   always #5 clk = ~clk;

   // Reference decoder with injectable faults.
   always_comb begin
      w_dec = '0;
      w_dec[dec_in] = 1'b1;
      if (fault == 1) w_dec[5] = 1'b0;
      if (fault == 2 && dec_in == 8'h10) w_dec[17] = 1'b1;
   end
   assign dec_out0 = w_dec[127:0];
   assign dec_out1 = w_dec[255:128];

   dec_sweep_ctrl #(.SETTLE(1), .CNT_W(20)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_num_vec(num_vec),
      .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready), .o_dec_in(dec_in),
      .i_dec_out0(dec_out0), .i_dec_out1(dec_out1), .o_busy(busy), .o_done(done),
      .o_vec_cnt(vec_cnt), .o_err_cnt(err_cnt)
`ifdef DEC_SWEEP_HAMMING_EN
      , .o_ham_max(ham_max)
`endif
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, s_ready, dec_in, vec_cnt, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b s_ready=%b dec_in=%h vec=%0d err=%0d, all must be 0",
                  busy, done, s_ready, dec_in, vec_cnt, err_cnt);
      end
`ifdef DEC_SWEEP_HAMMING_EN
      checks++;
      if (ham_max !== 9'd0) begin
         errors++;
         $display("FAIL reset_ham: got %0d want 0", ham_max);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Full sweep; optionally pulses a stray start at cycle inj (0 = none).
   task automatic run_sweep(input string name, input int exp_err, input int exp_ham, input int inj);
      int c;
      int done_c;
      logic [7:0] e;
      exp_q.delete();
      for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
      mode = 1'b0;
      start = 1'b1;
      done_c = -1;
      for (c = 1; c <= 1000; c++) begin
         @(negedge clk);
         start = 1'b0;
         mode  = 1'b0;
         if (inj != 0 && c == inj) begin
            start = 1'b1; mode = 1'b1; num_vec = 20'd3;
         end
         if (c % 3 == 2 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dec_in !== e) begin
               errors++;
               $display("FAIL %s dec_in: cycle %0d got %h want %h", name, c, dec_in, e);
            end
         end
         if (done === 1'b1) begin
            done_c = c;
            break;
         end
      end
      start = 1'b0;
      mode  = 1'b0;
      checks++;
      if (done_c != 769) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d want 769", name, done_c);
      end
      checks++;
      if (vec_cnt !== 20'd256 || err_cnt !== 20'(exp_err)) begin
         errors++;
         $display("FAIL %s counts: vec=%0d err=%0d want vec=256 err=%0d", name, vec_cnt, err_cnt, exp_err);
      end
`ifdef DEC_SWEEP_HAMMING_EN
      checks++;
      if (ham_max !== 9'(exp_ham)) begin
         errors++;
         $display("FAIL %s ham_max: got %0d want %0d", name, ham_max, exp_ham);
      end
`else
      if (exp_ham < 0) $display("note: negative ham expectation ignored");
`endif
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 20'd256) begin
         errors++;
         $display("FAIL %s post_done: busy=%b done=%b vec=%0d want 0 0 256", name, busy, done, vec_cnt);
      end
   endtask

   task automatic test_sweep_exact();
      fault = 0;
      run_sweep("sweep_exact", 0, 0, 0);
   endtask

   task automatic test_stuck_bit();
      fault = 1;
      run_sweep("stuck_bit5", 1, 1, 0);
      fault = 0;
   endtask

   task automatic test_extra_bit();
      fault = 2;
      run_sweep("extra_bit17", 1, 1, 0);
      fault = 0;
   endtask

   task automatic test_stream();
      logic [7:0] data [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
      logic [7:0] e;
      exp_q.delete();
      mode = 1'b1; num_vec = 20'd4; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (s_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_ready_fetch: vec %0d got %b want 1", i, s_ready);
            end
         end
         @(negedge clk);
         s_valid = 1'b1; s_data = data[i];
         if (s_ready === 1'b1) exp_q.push_back(data[i]);
         @(negedge clk);
         s_valid = 1'b0;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_handshake: vec %0d no transfer seen", i);
         end else begin
            e = exp_q.pop_front();
            if (dec_in !== e) begin
               errors++;
               $display("FAIL stream_dec_in: vec %0d got %h want %h", i, dec_in, e);
            end
         end
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream_ready_wait: vec %0d got %b want 0", i, s_ready);
         end
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b0 || dec_in !== data[i]) begin
            errors++;
            $display("FAIL stream_check_cycle: vec %0d s_ready=%b dec_in=%h want 0 %h", i, s_ready, dec_in, data[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || vec_cnt !== 20'd4 || err_cnt !== 20'd0) begin
         errors++;
         $display("FAIL stream_done: done=%b vec=%0d err=%0d want 1 4 0", done, vec_cnt, err_cnt);
      end
      @(negedge clk);
      mode = 1'b0;
   endtask

   task automatic test_stream_zero();
      int n_done = 0;
      int first = -1;
      int rdy = 0;
      mode = 1'b1; num_vec = 20'd0; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (s_ready === 1'b1) rdy++;
         if (done === 1'b1) begin
            n_done++;
            if (first < 0) first = c;
         end
      end
      mode = 1'b0;
      checks++;
      if (n_done != 1 || first < 1 || first > 2) begin
         errors++;
         $display("FAIL zero_done: pulses=%0d first_cycle=%0d want 1 pulse within 2 cycles", n_done, first);
      end
      checks++;
      if (rdy != 0 || vec_cnt !== 20'd0 || err_cnt !== 20'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_state: ready_cycles=%0d vec=%0d err=%0d busy=%b want 0 0 0 0", rdy, vec_cnt, err_cnt, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int nd = 0;
      mode = 1'b0; start = 1'b1;
      for (int c = 1; c <= 302; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (dec_in !== 8'd100 || vec_cnt !== 20'd100 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre: dec_in=%0d vec=%0d busy=%b want 100 100 1", dec_in, vec_cnt, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || vec_cnt !== 20'd0 || err_cnt !== 20'd0 || dec_in !== 8'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b vec=%0d err=%0d dec_in=%h done=%b want all 0",
                  busy, vec_cnt, err_cnt, dec_in, done);
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) nd++;
      end
      checks++;
      if (nd != 0) begin
         errors++;
         $display("FAIL midrun_idle: %0d cycles with busy/done after reset, want 0", nd);
      end
      fault = 0;
      run_sweep("after_reset", 0, 0, 0);
   endtask

   task automatic test_start_while_busy();
      fault = 1;
      run_sweep("start_busy", 1, 1, 40);
      fault = 0;
   endtask

   initial begin
      test_reset();
      test_sweep_exact();
      test_stuck_bit();
      test_extra_bit();
      test_stream();
      test_stream_zero();
      test_reset_mid_run();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dec_sweep_ctrl.md
# dec_sweep_ctrl

Sequencing controller for the 8-to-256 one-hot decoder (`dec`) under approximate-logic evaluation. It drives the decoder's 8-bit input from either an exhaustive 0..255 sweep or a valid/ready vector stream. It waits a configurable settle time, then captures the two 128-bit output halves and compares them against the exact one-hot result. It counts applied vectors and erroneous vectors, so error-rate figures come from hardware rather than from post-processing a dump.

## Interface
- `SETTLE`, default 1: cycles between driving `dec_in` and sampling the decoder outputs (≥1).
- `CNT_W`, default 20: width of vector/error counters and `num_vec`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `mode`  in  1  0 = exhaustive sweep 0..255, 1 = stream; sampled with `start`.
- `num_vec`  in  CNT_W  vectors to apply in stream mode; sampled with `start`.
- `s_valid`  in  1  stream vector valid.
- `s_data`  in  8  stream vector.
- `s_ready`  out  1  controller accepts `s_data` this cycle.
- `dec_in`  out  8  registered decoder input.
- `dec_out0`  in  128  decoder output bits 127:0.
- `dec_out1`  in  128  decoder output bits 255:128.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `vec_cnt`  out  CNT_W  vectors checked in the current/last run.
- `err_cnt`  out  CNT_W  vectors whose `{dec_out1,dec_out0}` ≠ `1 << dec_in`.

## Operation
- Reset: state IDLE, `dec_in`=0, `vec_cnt`=0, `err_cnt`=0, `busy`=0, `done`=0, `s_ready`=0, capture register 0.
- IDLE: `start`=1 clears counters, latches `mode`/`num_vec`, clears sweep index, then goes to FETCH. If the target is 0 (stream mode with `num_vec`=0), it goes directly to DONE.
- FETCH, mode 0: `dec_in` ← index, then WAIT.
- FETCH, mode 1: `s_ready`=1 (combinational from state). When `s_valid` is high, `dec_in` ← `s_data`, then WAIT. Otherwise the controller stays in FETCH indefinitely.
- WAIT: settle counter is loaded with `SETTLE`. When it expires, `{dec_out1,dec_out0}` is registered into the capture register, then CHECK.
- CHECK: capture is compared with the 256-bit one-hot of `dec_in`. `vec_cnt`++; `err_cnt`++ on mismatch.
  - If `vec_cnt`+1 = target (256 in mode 0, `num_vec` in mode 1), go to DONE.
  - Otherwise go to FETCH; in mode 0 the index is also incremented.
- DONE: `done`=1 for one cycle, then IDLE. Counters hold until the next `start`.
- `busy`=1 in FETCH/WAIT/CHECK/DONE.
- `start` outside IDLE is ignored.
- Counter rules:
  - `vec_cnt` cannot exceed target ≤ 2^CNT_W−1, so there is no wrap.
  - `err_cnt` ≤ `vec_cnt`.
  - The 8-bit sweep index wraps 255→0 only after the final CHECK, so this is never observable.
- `rst` mid-run returns everything to reset values on the next edge. The partial counts are lost and no `done` pulse is produced.

## Timing
- Per vector: FETCH 1 cycle (+ stream stall) + WAIT `SETTLE` cycles + CHECK 1 cycle.
- Mode 0, `SETTLE`=1: vector k occupies cycles 3k+1..3k+3 after the `start` sampling edge. `done` is high in cycle 769.
- `dec_in` changes only on the FETCH exit edge. It is stable through WAIT and CHECK.
- `vec_cnt`/`err_cnt` update on the CHECK exit edge.
- Stream handshake: transfer occurs on an edge with `s_valid` & `s_ready`. `s_ready` is 0 outside FETCH.

## Configuration
- `DEC_SWEEP_HAMMING_EN` defined:
  - Adds output port `ham_max` (9 bits, reset 0, cleared on `start`).
  - In CHECK it updates to max(`ham_max`, popcount(capture ^ expected)).
  - Range 0..256.
- Undefined: `ham_max` port and popcount logic absent; all other behaviour identical.

## Structure
- `dec_sweep_pkg` contains:
  - state enum (IDLE, FETCH, WAIT, CHECK, DONE);
  - `IN_W`=8 and `OUT_W`=256;
  - `MODE_SWEEP`=0 and `MODE_STREAM`=1.
- Sub-module `dec_sweep_popcnt`: 256-bit adder-tree popcount, instantiated only under `DEC_SWEEP_HAMMING_EN`.

## Test plan
- Exact decoder, mode 0, `SETTLE`=1, `start` → `done` in cycle 769, `vec_cnt`=256, `err_cnt`=0, `ham_max`=0.
- Decoder with output bit 5 stuck at 0, mode 0 → `err_cnt`=1, `vec_cnt`=256, `ham_max`=1.
- Decoder that also sets bit 17 when the input is 0x10 → `err_cnt`=1, `ham_max`=1.
- Mode 1, `num_vec`=4, `s_data` 0x00, 0xFF, 0x80, 0x7F with 2-cycle `s_valid` gaps → `dec_in` follows in order, `s_ready` high only in FETCH, `vec_cnt`=4, `err_cnt`=0.
- Mode 1, `num_vec`=0 → `done` two cycles after the `start` edge, counters 0, `s_ready` never high.
- `rst` pulsed during vector 100 of a sweep → next cycle `busy`=0, counters 0, `dec_in`=0, no `done`. A following `start` completes the full 256-vector sweep.
- `start` pulsed while `busy` → ignored; run finishes with unchanged counts.
